// File: rtl/coin_acceptor.sv
// coin_acceptor
// Front-end for the credit counter. Counts rising edges on the three coin-slot
// sensors into a pending total, then hands the total to the credit counter as a
// one-cycle money/set load. The load happens on a confirm press, or on its own
// once no coin has arrived for TIMEOUT cycles.
//
// Parameters:
//   WIDTH      width of every credit value
//   MAX_CREDIT saturation ceiling for the pending total
//   TIMEOUT    idle cycles after the last coin before the automatic commit (>= 2)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   coin1      1-unit slot sensor level; each rising edge is one coin
//   coin5      5-unit slot sensor level; each rising edge is one coin
//   coin10     10-unit slot sensor level; each rising edge is one coin
//   confirm    confirm button level; a rising edge commits at once
//   money      committed value, nonzero only while set=1
//   set        one-cycle load strobe for the credit counter
//   pending    running total that has not been committed yet
//   ovf        pending total reached MAX_CREDIT; cleared by the next commit
//
// Optional build macro COIN_REFUND_EN adds:
//   cancel     cancel button level; a rising edge while collecting refunds
//   refund     one-cycle refund strobe
//   refund_val refunded amount, nonzero only while refund=1
module coin_acceptor #(
   parameter int WIDTH      = 10,
   parameter int MAX_CREDIT = 999,
   parameter int TIMEOUT    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             coin1,
   input  logic             coin5,
   input  logic             coin10,
   input  logic             confirm,
`ifdef COIN_REFUND_EN
   input  logic             cancel,
   output logic             refund,
   output logic [WIDTH-1:0] refund_val,
`endif
   output logic [WIDTH-1:0] money,
   output logic             set,
   output logic [WIDTH-1:0] pending,
   output logic             ovf
);

   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0]  T_LOAD = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0]  T_ONE  = TW'(1);
   localparam logic [WIDTH:0] MAX_W  = (WIDTH + 1)'(MAX_CREDIT);
   localparam logic [WIDTH:0] V1     = (WIDTH + 1)'(1);
   localparam logic [WIDTH:0] V5     = (WIDTH + 1)'(5);
   localparam logic [WIDTH:0] V10    = (WIDTH + 1)'(10);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      COMMIT
   } state_t;

   // Clamp a one-bit-wider total to the credit ceiling.
   function automatic logic [WIDTH-1:0] sat_credit(input logic [WIDTH:0] total);
      if (total >= MAX_W)
         return MAX_W[WIDTH-1:0];
      else
         return total[WIDTH-1:0];
   endfunction

   state_t           state, state_nxt;
   logic             prev1, prev5, prev10, prev_confirm;
   logic             e1, e5, e10, confirm_edge, cancel_edge;
   logic [WIDTH:0]   cval;
   logic [WIDTH:0]   sum;
   logic [TW-1:0]    timer, timer_nxt;
   logic [WIDTH-1:0] pending_nxt, money_nxt;
   logic             set_nxt, ovf_nxt;

`ifdef COIN_REFUND_EN
   logic             prev_cancel;
   logic             refund_nxt;
   logic [WIDTH-1:0] refund_val_nxt;
   assign cancel_edge = cancel & ~prev_cancel;
`else
   assign cancel_edge = 1'b0;
`endif

   // Edge detection: a level held high counts only on its first cycle.
   assign e1           = coin1   & ~prev1;
   assign e5           = coin5   & ~prev5;
   assign e10          = coin10  & ~prev10;
   assign confirm_edge = confirm & ~prev_confirm;

   // Coins arriving together all count in the same cycle.
   always_comb begin
      cval = '0;
      if (e1)
         cval = cval + V1;
      if (e5)
         cval = cval + V5;
      if (e10)
         cval = cval + V10;
   end

   // One extra bit so pending + cval never wraps before saturation.
   assign sum = {1'b0, pending} + cval;

   always_comb begin
      state_nxt   = state;
      pending_nxt = pending;
      timer_nxt   = timer;
      ovf_nxt     = ovf;
      set_nxt     = 1'b0;
      money_nxt   = '0;
`ifdef COIN_REFUND_EN
      refund_nxt     = 1'b0;
      refund_val_nxt = '0;
`endif
      case (state)
         IDLE: begin
            // pending is zero here, so sum equals cval; a bare confirm is ignored.
            if (cval != '0) begin
               state_nxt   = COLLECT;
               pending_nxt = sat_credit(sum);
               ovf_nxt     = (sum >= MAX_W);
               timer_nxt   = T_LOAD;
            end
         end
         COLLECT: begin
            if (cancel_edge) begin
               // Cancel beats confirm; coins in this cycle are refunded too.
               state_nxt   = IDLE;
               pending_nxt = '0;
               ovf_nxt     = 1'b0;
               timer_nxt   = '0;
`ifdef COIN_REFUND_EN
               refund_nxt     = 1'b1;
               refund_val_nxt = sat_credit(sum);
`endif
            end else if (confirm_edge) begin
               // A coin in the confirm cycle is part of this commit.
               state_nxt   = COMMIT;
               pending_nxt = sat_credit(sum);
               money_nxt   = sat_credit(sum);
               set_nxt     = 1'b1;
               ovf_nxt     = 1'b0;
               timer_nxt   = '0;
            end else if (cval != '0) begin
               pending_nxt = sat_credit(sum);
               ovf_nxt     = ovf | (sum >= MAX_W);
               timer_nxt   = T_LOAD;
            end else if (timer == '0) begin
               state_nxt = COMMIT;
               money_nxt = pending;
               set_nxt   = 1'b1;
               ovf_nxt   = 1'b0;
            end else begin
               timer_nxt = timer - T_ONE;
            end
         end
         COMMIT: begin
            // A coin landing during the strobe starts the next collection.
            if (cval != '0) begin
               state_nxt   = COLLECT;
               pending_nxt = sat_credit(cval);
               ovf_nxt     = (cval >= MAX_W);
               timer_nxt   = T_LOAD;
            end else begin
               state_nxt   = IDLE;
               pending_nxt = '0;
               timer_nxt   = '0;
            end
         end
         default: begin
            state_nxt   = IDLE;
            pending_nxt = '0;
            timer_nxt   = '0;
            ovf_nxt     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         prev1        <= 1'b0;
         prev5        <= 1'b0;
         prev10       <= 1'b0;
         prev_confirm <= 1'b0;
         timer        <= '0;
         pending      <= '0;
         money        <= '0;
         set          <= 1'b0;
         ovf          <= 1'b0;
`ifdef COIN_REFUND_EN
         prev_cancel  <= 1'b0;
         refund       <= 1'b0;
         refund_val   <= '0;
`endif
      end else begin
         state        <= state_nxt;
         prev1        <= coin1;
         prev5        <= coin5;
         prev10       <= coin10;
         prev_confirm <= confirm;
         timer        <= timer_nxt;
         pending      <= pending_nxt;
         money        <= money_nxt;
         set          <= set_nxt;
         ovf          <= ovf_nxt;
`ifdef COIN_REFUND_EN
         prev_cancel  <= cancel;
         refund       <= refund_nxt;
         refund_val   <= refund_val_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_coin_acceptor.sv
// Testbench for coin_acceptor with default parameters (WIDTH=10,
// MAX_CREDIT=999, TIMEOUT=16). Directed table of per-cycle vectors plus
// hand-written sequences for saturation, reset and the optional refund path.
module tb_coin_acceptor;

   localparam int W = 10;

   logic         clk = 1'b0;
   logic         rst;
   logic         coin1, coin5, coin10, confirm;
   logic [W-1:0] money, pending;
   logic         set, ovf;
`ifdef COIN_REFUND_EN
   logic         cancel;
   logic         refund;
   logic [W-1:0] refund_val;
`endif

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   coin_acceptor #(
      .WIDTH(W),
      .MAX_CREDIT(999),
      .TIMEOUT(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .coin1(coin1),
      .coin5(coin5),
      .coin10(coin10),
      .confirm(confirm),
`ifdef COIN_REFUND_EN
      .cancel(cancel),
      .refund(refund),
      .refund_val(refund_val),
`endif
      .money(money),
      .set(set),
      .pending(pending),
      .ovf(ovf)
   );

   typedef struct {
      logic c1;
      logic c5;
      logic c10;
      logic conf;
      int   pend;
      int   st;
      int   mon;
      int   ov;
   } vec_t;

   vec_t tbl[$];

   task automatic push(input logic c1, input logic c5, input logic c10,
                       input logic conf, input int pend, input int st,
                       input int mon, input int ov);
      vec_t v;
      v.c1 = c1; v.c5 = c5; v.c10 = c10; v.conf = conf;
      v.pend = pend; v.st = st; v.mon = mon; v.ov = ov;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp)
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      else
         passed++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input int p, input int s, input int m, input int o);
      chk({tag, ".pending"}, int'(pending), p);
      chk({tag, ".set"}, int'(set), s);
      chk({tag, ".money"}, int'(money), m);
      chk({tag, ".ovf"}, int'(ovf), o);
   endtask

   initial begin
      int nset;
      int mset;

      rst = 1'b1;
      coin1 = 1'b0; coin5 = 1'b0; coin10 = 1'b0; confirm = 1'b0;
`ifdef COIN_REFUND_EN
      cancel = 1'b0;
`endif

      // Vector table: inputs for one cycle, outputs expected after that edge.
      // coin5, coin10 three cycles later, auto-commit 16 edges after coin10.
      push(0,1,0,0,  5,0, 0,0);
      push(0,0,0,0,  5,0, 0,0);
      push(0,0,0,0,  5,0, 0,0);
      push(0,0,1,0, 15,0, 0,0);
      for (int i = 0; i < 15; i++)
         push(0,0,0,0, 15,0, 0,0);
      push(0,0,0,0, 15,1,15,0);
      push(0,0,0,0,  0,0, 0,0);
      // Three coins together, confirm two cycles later.
      push(1,1,1,0, 16,0, 0,0);
      push(0,0,0,0, 16,0, 0,0);
      push(0,0,0,1, 16,1,16,0);
      push(0,0,0,0,  0,0, 0,0);
      // Confirm in IDLE does nothing.
      push(0,0,0,1,  0,0, 0,0);
      push(0,0,0,0,  0,0, 0,0);
      // Commit of 7 with a coin1 edge during the COMMIT cycle.
      push(1,1,0,0,  6,0, 0,0);
      push(0,0,0,0,  6,0, 0,0);
      push(1,0,0,0,  7,0, 0,0);
      push(0,0,0,1,  7,1, 7,0);
      push(1,0,0,0,  1,0, 0,0);
      push(0,0,0,1,  1,1, 1,0);
      push(0,0,0,0,  0,0, 0,0);
      // Coin and confirm in the same cycle: coin is included.
      push(0,1,0,0,  5,0, 0,0);
      push(0,0,1,1, 15,1,15,0);
      push(0,0,0,0,  0,0, 0,0);

      repeat (2) tick();
      chk_all("reset", 0, 0, 0, 0);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         coin1 = tbl[i].c1; coin5 = tbl[i].c5; coin10 = tbl[i].c10; confirm = tbl[i].conf;
         tick();
         chk_all($sformatf("vec%0d", i), tbl[i].pend, tbl[i].st, tbl[i].mon, tbl[i].ov);
      end
      coin1 = 1'b0; coin5 = 1'b0; coin10 = 1'b0; confirm = 1'b0;

      // coin10 held high for 40 cycles counts once and auto-commits 10.
      coin10 = 1'b1;
      tick();
      chk("hold.first", int'(pending), 10);
      nset = 0; mset = 0;
      for (int i = 0; i < 39; i++) begin
         tick();
         if (set) begin
            nset++;
            mset = int'(money);
         end
      end
      chk("hold.set_count", nset, 1);
      chk("hold.money", mset, 10);
      chk("hold.pending", int'(pending), 0);

      // 100 rising edges of coin10 saturate at 999.
      for (int i = 0; i < 100; i++) begin
         coin10 = 1'b0;
         tick();
         coin10 = 1'b1;
         tick();
         if (i == 98) begin
            chk("sat.pending990", int'(pending), 990);
            chk("sat.ovf990", int'(ovf), 0);
         end
      end
      chk("sat.pending", int'(pending), 999);
      chk("sat.ovf", int'(ovf), 1);
      coin10 = 1'b0;
      confirm = 1'b1;
      tick();
      chk("sat.set", int'(set), 1);
      chk("sat.money", int'(money), 999);
      confirm = 1'b0;
      tick();
      chk_all("sat.after", 0, 0, 0, 0);

      // Build pending=23, then reset mid-cycle.
      coin10 = 1'b1; coin5 = 1'b1;
      tick();
      coin10 = 1'b0; coin5 = 1'b0;
      tick();
      coin5 = 1'b1; coin1 = 1'b1;
      tick();
      coin5 = 1'b0; coin1 = 1'b0;
      tick();
      coin1 = 1'b1;
      tick();
      coin1 = 1'b0;
      tick();
      coin1 = 1'b1;
      tick();
      coin1 = 1'b0;
      chk("rst.pre_pending", int'(pending), 23);
      #2 rst = 1'b1;
      #1;
      chk_all("rst.async", 0, 0, 0, 0);
      tick();
      tick();
      rst = 1'b0;
      nset = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (set) nset++;
      end
      chk("rst.no_set", nset, 0);
      chk("rst.pending", int'(pending), 0);
      confirm = 1'b1;
      tick();
      confirm = 1'b0;
      nset = int'(set);
      for (int i = 0; i < 5; i++) begin
         tick();
         if (set) nset++;
      end
      chk("rst.confirm_alone", nset, 0);

`ifdef COIN_REFUND_EN
      coin5 = 1'b1;
      tick();
      chk("ref.p5", int'(pending), 5);
      coin5 = 1'b0;
      tick();
      coin5 = 1'b1;
      tick();
      chk("ref.p10", int'(pending), 10);
      coin5 = 1'b0;
      cancel = 1'b1;
      tick();
      chk("ref.refund", int'(refund), 1);
      chk("ref.refund_val", int'(refund_val), 10);
      chk("ref.set", int'(set), 0);
      chk("ref.pending", int'(pending), 0);
      cancel = 1'b0;
      tick();
      chk("ref.refund_off", int'(refund), 0);
      chk("ref.refund_val_off", int'(refund_val), 0);
      chk("ref.set_off", int'(set), 0);
      coin1 = 1'b1;
      tick();
      chk("ref2.p1", int'(pending), 1);
      coin1 = 1'b0;
      cancel = 1'b1;
      confirm = 1'b1;
      tick();
      chk("ref2.refund", int'(refund), 1);
      chk("ref2.refund_val", int'(refund_val), 1);
      chk("ref2.set", int'(set), 0);
      cancel = 1'b0;
      confirm = 1'b0;
      tick();
      chk("ref2.set_after", int'(set), 0);
      chk("ref2.pending", int'(pending), 0);
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Front-end that feeds the credit counter: takes coin-slot pulses, totals them into a pending credit, then commits the total as a one-cycle money/set load.
- Commit happens on a confirm press or after an inactivity timeout.
- Output pair money/set connects directly to the credit counter's money/set inputs.

Parameters:
- WIDTH, 10, width of all credit values.
- MAX_CREDIT, 999, saturation ceiling for the pending total.
- TIMEOUT, 16, idle cycles after the last coin before auto-commit (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- coin1  input  1  level from 1-unit slot sensor; each rising edge is one coin.
- coin5  input  1  level from 5-unit slot sensor; each rising edge is one coin.
- coin10  input  1  level from 10-unit slot sensor; each rising edge is one coin.
- confirm  input  1  level; a rising edge commits immediately.
- money  output  WIDTH  committed credit value; valid only while set=1, 0 otherwise.
- set  output  1  one-cycle load strobe to the credit counter.
- pending  output  WIDTH  running uncommitted total.
- ovf  output  1  pending total hit MAX_CREDIT; cleared on the next commit.

Behaviour:
- Reset, asynchronous and active-high:
  - money=0, set=0, pending=0, ovf=0.
  - Edge-detect history registers=0, timer=0, state=IDLE.
  - Reset mid-COLLECT discards the pending total; no set is issued.
- Edge detection:
  - Each input has a registered previous value; edge = in & ~prev.
  - A level held high counts once.
  - Inputs are already synchronous; no debounce.
- Coin value per cycle: cval = 1·e1 + 5·e5 + 10·e10.
  - Simultaneous edges all count in the same cycle (max 16).
- Accumulation: pending_next = min(pending + cval, MAX_CREDIT).
  - Compute with WIDTH+1 bits so there is no wrap.
  - If the sum is >= MAX_CREDIT, set ovf=1.
- States:
  - IDLE: pending=0, timer idle.
    - cval!=0 -> COLLECT, with pending=cval and timer=TIMEOUT-1.
    - A confirm edge in IDLE is ignored; a zero-value set is never issued.
  - COLLECT:
    - Each cycle with cval!=0: add to pending, reload timer=TIMEOUT-1.
    - Otherwise the timer decrements.
    - A confirm edge, or timer==0 with no coin that cycle -> COMMIT.
    - Confirm edge and coin edge in the same cycle: the coin is added first, then -> COMMIT. The committed value includes that coin.
  - COMMIT, one cycle: set=1, money=pending (registered output), ovf cleared.
    - Coin edge during COMMIT: pending<=cval, timer reloaded, -> COLLECT. The coin is never lost and is not part of this commit.
    - Otherwise pending<=0 -> IDLE.
- Latency:
  - From the last coin edge (sampled at clock k), with no confirm, set asserts in cycle k+TIMEOUT+1.
  - From a confirm edge sampled at k, set asserts in cycle k+1.
- Back-to-back commits are at least 2 cycles apart.
- pending is a registered output, updated the cycle after the edge is sampled.

Optional Feature:
- Macro: COIN_REFUND_EN.
- Defined:
  - Adds input cancel (1 bit, rising edge active).
  - Adds outputs refund (1-bit one-cycle strobe) and refund_val (WIDTH).
  - A cancel edge in COLLECT -> one-cycle refund=1 with refund_val=pending, then pending=0, ovf=0, -> IDLE. No set is issued.
  - Coin edges in the cancel cycle are included in the refund.
  - Cancel and confirm edges in the same cycle: cancel wins.
  - Cancel in IDLE or COMMIT is ignored.
  - refund_val=0 whenever refund=0.
- Not defined: the ports do not exist and there is no refund path.

Test Plan:
- Coin edges on coin5, then coin10, three cycles apart, no confirm, TIMEOUT=16 -> pending 5 then 15; set=1 for one cycle with money=15 exactly 17 cycles after the coin10 edge; pending returns to 0.
- Edges on coin1, coin5 and coin10 in the same cycle, then a confirm edge 2 cycles later -> pending=16; the cycle after the confirm shows set=1, money=16.
- coin10 held high 40 cycles, then toggled 100 times with MAX_CREDIT=999 -> the held level counts once; pending saturates at 999, ovf=1; commit gives money=999 and ovf clears.
- coin1 edge in the COMMIT cycle of a money=7 commit -> set=1, money=7; next cycle pending=1, state COLLECT; a later commit gives money=1.
- Reset asserted mid-COLLECT with pending=23 -> all outputs 0 immediately; no set after release; confirm alone after reset -> no set.
- With COIN_REFUND_EN defined: coin5 twice, cancel edge -> refund=1, refund_val=10 for one cycle; set never asserted; pending=0. Cancel and confirm in the same cycle -> refund only.
